// File: rtl/coefficient_scheduler_pkg.sv
// Shared types and constants for the coefficient scheduler.
package coefficient_scheduler_pkg;
    localparam int c_datawidth      = 32;
    localparam int c_fractionlength = 16;
    localparam int c_numCoeff       = 13;
    localparam int c_addrWidth      = 4;

    typedef logic signed [c_datawidth-1:0] t_coeff;
    typedef t_coeff [c_numCoeff-1:0]       t_coeffBank;
    typedef t_coeffBank                    t_coefficients;

    typedef enum logic {IDLE, PENDING} t_schedState;

    localparam int c_tapNorth  = 2;
    localparam int c_tapWest   = 5;
    localparam int c_tapCenter = 6;
    localparam int c_tapEast   = 7;
    localparam int c_tapSouth  = 10;
endpackage

// File: rtl/coefficient_scheduler_if.sv
// Host write/commit port and grid-facing coefficient outputs.
// Readback signals exist only with COEFF_SCHED_READBACK_EN.
interface coefficient_scheduler_if #(
    parameter int g_addrWidth = 4,
    parameter int g_dataWidth = 32
);
    import coefficient_scheduler_pkg::*;

    logic                   i_wrValid;
    logic                   o_wrReady;
    logic                   i_wrBank;
    logic [g_addrWidth-1:0] i_wrAddr;
    logic [g_dataWidth-1:0] i_wrData;
    logic                   i_commit;
    logic                   o_commitPending;
    logic                   o_commitDone;
    logic                   i_frameDone;
    t_coefficients          o_coefficientsN;
    t_coefficients          o_coefficientsNMinus1;
    logic [31:0]            o_frameCount;
    logic                   o_addrError;
`ifdef COEFF_SCHED_READBACK_EN
    logic                   i_rdBank;
    logic                   i_rdShadow;
    logic [g_addrWidth-1:0] i_rdAddr;
    logic [g_dataWidth-1:0] o_rdData;

    modport slave (
        input  i_wrValid, i_wrBank, i_wrAddr, i_wrData, i_commit, i_frameDone,
               i_rdBank, i_rdShadow, i_rdAddr,
        output o_wrReady, o_commitPending, o_commitDone, o_coefficientsN,
               o_coefficientsNMinus1, o_frameCount, o_addrError, o_rdData
    );
    modport master (
        output i_wrValid, i_wrBank, i_wrAddr, i_wrData, i_commit, i_frameDone,
               i_rdBank, i_rdShadow, i_rdAddr,
        input  o_wrReady, o_commitPending, o_commitDone, o_coefficientsN,
               o_coefficientsNMinus1, o_frameCount, o_addrError, o_rdData
    );
`else
    modport slave (
        input  i_wrValid, i_wrBank, i_wrAddr, i_wrData, i_commit, i_frameDone,
        output o_wrReady, o_commitPending, o_commitDone, o_coefficientsN,
               o_coefficientsNMinus1, o_frameCount, o_addrError
    );
    modport master (
        output i_wrValid, i_wrBank, i_wrAddr, i_wrData, i_commit, i_frameDone,
        input  o_wrReady, o_commitPending, o_commitDone, o_coefficientsN,
               o_coefficientsNMinus1, o_frameCount, o_addrError
    );
`endif
endinterface

// File: rtl/coefficient_scheduler_coeff_bank.sv
// One shadow/active coefficient register pair with write port and copy strobe.
// Optional combinational read mux under COEFF_SCHED_READBACK_EN (registered in the top).
module coefficient_scheduler_coeff_bank #(
    parameter int g_numCoeff  = 13,
    parameter int g_dataWidth = 32,
    parameter int g_addrWidth = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    wr_en,
    input  logic [g_addrWidth-1:0]                  wr_addr,
    input  logic [g_dataWidth-1:0]                  wr_data,
    input  logic                                    copy,
    output logic [g_numCoeff-1:0][g_dataWidth-1:0]  active_o
`ifdef COEFF_SCHED_READBACK_EN
    ,
    input  logic                                    rd_shadow,
    input  logic [g_addrWidth-1:0]                  rd_addr,
    output logic [g_dataWidth-1:0]                  rd_val
`endif
);
    logic [g_numCoeff-1:0][g_dataWidth-1:0] shadow_q, shadow_d;
    logic [g_numCoeff-1:0][g_dataWidth-1:0] active_q, active_d;

    // wr_en is only raised for in-range addresses, so the index is always valid.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (wr_en) shadow_d[wr_addr] = wr_data;
        if (copy)  active_d = shadow_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign active_o = active_q;

`ifdef COEFF_SCHED_READBACK_EN
    always_comb begin
        rd_val = '0;
        if (int'(rd_addr) < g_numCoeff)
            rd_val = rd_shadow ? shadow_q[rd_addr] : active_q[rd_addr];
    end
`endif
endmodule

// File: rtl/coefficient_scheduler.sv
// Double-buffered N / N-1 coefficient banks published only at timestep boundaries,
// plus a timestep counter. Readback port enabled by COEFF_SCHED_READBACK_EN.
module coefficient_scheduler
    import coefficient_scheduler_pkg::*;
#(
    parameter int g_numCoeff  = c_numCoeff,
    parameter int g_dataWidth = c_datawidth,
    parameter int g_addrWidth = c_addrWidth
) (
    input logic                    i_clk,
    input logic                    i_reset,
    coefficient_scheduler_if.slave bus
);
    t_schedState state_q, state_d;
    logic        wr_ready_q, wr_ready_d;
    logic        pending_q, pending_d;
    logic        done_q, done_d;
    logic        addr_err_q, addr_err_d;
    logic [31:0] frame_count_q, frame_count_d;
    logic        copy, wr_accept, addr_in;

    logic [1:0][g_numCoeff-1:0][g_dataWidth-1:0] bank_active;

    assign wr_accept = bus.i_wrValid & wr_ready_q;
    assign addr_in   = int'(bus.i_wrAddr) < g_numCoeff;

    always_comb begin
        state_d       = state_q;
        wr_ready_d    = wr_ready_q;
        pending_d     = pending_q;
        done_d        = 1'b0;
        copy          = 1'b0;
        addr_err_d    = addr_err_q | (wr_accept & ~addr_in);
        frame_count_d = frame_count_q + 32'(bus.i_frameDone);
        case (state_q)
            IDLE: begin
                wr_ready_d = 1'b1;
                // A boundary in the commit cycle is skipped: a full sweep must follow.
                if (bus.i_commit) begin
                    state_d    = PENDING;
                    wr_ready_d = 1'b0;
                    pending_d  = 1'b1;
                end
            end
            PENDING: begin
                if (bus.i_frameDone) begin
                    copy       = 1'b1;
                    state_d    = IDLE;
                    wr_ready_d = 1'b1;
                    pending_d  = 1'b0;
                    done_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= IDLE;
            wr_ready_q    <= 1'b0;
            pending_q     <= 1'b0;
            done_q        <= 1'b0;
            addr_err_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_ready_q    <= wr_ready_d;
            pending_q     <= pending_d;
            done_q        <= done_d;
            addr_err_q    <= addr_err_d;
            frame_count_q <= frame_count_d;
        end
    end

`ifdef COEFF_SCHED_READBACK_EN
    logic [1:0][g_dataWidth-1:0] rd_val;
    logic [g_dataWidth-1:0]      rd_data_q, rd_data_d;

    assign rd_data_d = rd_val[bus.i_rdBank];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) rd_data_q <= '0;
        else         rd_data_q <= rd_data_d;
    end

    assign bus.o_rdData = rd_data_q;
`endif

    // Bank 0 drives the N coefficients, bank 1 the N-1 coefficients.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        coefficient_scheduler_coeff_bank #(
            .g_numCoeff (g_numCoeff),
            .g_dataWidth(g_dataWidth),
            .g_addrWidth(g_addrWidth)
        ) u_bank (
            .clk      (i_clk),
            .rst      (i_reset),
            .wr_en    (wr_accept & addr_in & (bus.i_wrBank == 1'(b))),
            .wr_addr  (bus.i_wrAddr),
            .wr_data  (bus.i_wrData),
            .copy     (copy),
            .active_o (bank_active[b])
`ifdef COEFF_SCHED_READBACK_EN
            ,
            .rd_shadow(bus.i_rdShadow),
            .rd_addr  (bus.i_rdAddr),
            .rd_val   (rd_val[b])
`endif
        );
    end

    assign bus.o_wrReady             = wr_ready_q;
    assign bus.o_commitPending       = pending_q;
    assign bus.o_commitDone          = done_q;
    assign bus.o_addrError           = addr_err_q;
    assign bus.o_frameCount          = frame_count_q;
    assign bus.o_coefficientsN       = bank_active[0];
    assign bus.o_coefficientsNMinus1 = bank_active[1];
endmodule

// File: tb/tb_coefficient_scheduler.sv
// Self-checking bench: table-driven writes, commit scoreboard, boundary sequences.
module tb_coefficient_scheduler;
    import coefficient_scheduler_pkg::*;

    localparam int BW = $bits(t_coefficients);

    typedef struct {
        logic        bank;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        exp_err;
    } wr_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    coefficient_scheduler_if bus ();
    coefficient_scheduler dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    int checks = 0;
    int fails  = 0;
    int exp_frames = 0;

    t_coeffBank sh_model [2];
    t_coeffBank act_model[2];
    logic [2*BW-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst && bus.i_frameDone) exp_frames++;
        #1;
    endtask

    task automatic do_write(input logic bank, input logic [3:0] addr, input logic [31:0] data);
        bus.i_wrValid = 1'b1; bus.i_wrBank = bank; bus.i_wrAddr = addr; bus.i_wrData = data;
        chk("wr_ready", BW'(bus.o_wrReady), BW'(1));
        step();
        bus.i_wrValid = 1'b0;
        if (int'(addr) < c_numCoeff) sh_model[bank][addr] = data;
    endtask

    // Commit request: expected published data is the shadow model at this point.
    task automatic push_commit();
        exp_q.push_back({sh_model[0], sh_model[1]});
    endtask

    // Scoreboard: every commit-done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && bus.o_commitDone) begin
            if (exp_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_commit_done actual=1 expected=0");
            end else begin
                logic [2*BW-1:0] e;
                e = exp_q.pop_front();
                chk("sb_coefN", bus.o_coefficientsN, e[2*BW-1:BW]);
                chk("sb_coefNm1", bus.o_coefficientsNMinus1, e[BW-1:0]);
                act_model[0] = e[2*BW-1:BW];
                act_model[1] = e[BW-1:0];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    wr_vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b0, 4'd6,  32'h0000045f, 1'b0};
        vecs[1] = '{1'b0, 4'd2,  32'h00007ee3, 1'b0};
        vecs[2] = '{1'b0, 4'd5,  32'h00007ee3, 1'b0};
        vecs[3] = '{1'b0, 4'd7,  32'h00007ee3, 1'b0};
        vecs[4] = '{1'b0, 4'd10, 32'h00007ee3, 1'b0};
        vecs[5] = '{1'b1, 4'd6,  32'hffff0015, 1'b0};
        for (int b = 0; b < 2; b++) begin sh_model[b] = '0; act_model[b] = '0; end

        bus.i_wrValid = 0; bus.i_wrBank = 0; bus.i_wrAddr = 0; bus.i_wrData = 0;
        bus.i_commit = 0; bus.i_frameDone = 0;
`ifdef COEFF_SCHED_READBACK_EN
        bus.i_rdBank = 0; bus.i_rdShadow = 0; bus.i_rdAddr = 0;
`endif
        // Reset state
        #1;
        chk("rst_coefN", bus.o_coefficientsN, '0);
        chk("rst_coefNm1", bus.o_coefficientsNMinus1, '0);
        chk("rst_frames", BW'(bus.o_frameCount), '0);
        chk("rst_ready", BW'(bus.o_wrReady), '0);
        chk("rst_pending", BW'(bus.o_commitPending), '0);
        chk("rst_done", BW'(bus.o_commitDone), '0);
        chk("rst_err", BW'(bus.o_addrError), '0);
        step(); step(); step();
        rst = 1'b0;
        repeat (5) step();
        chk("idle_ready", BW'(bus.o_wrReady), BW'(1));
        chk("idle_coefN", bus.o_coefficientsN, '0);
        chk("idle_frames", BW'(bus.o_frameCount), '0);

        // Table-driven writes; active bank must not move yet
        for (int i = 0; i < 6; i++) begin
            do_write(vecs[i].bank, vecs[i].addr, vecs[i].data);
            chk("tbl_err", BW'(bus.o_addrError), BW'(vecs[i].exp_err));
            chk("tbl_coefN_hold", bus.o_coefficientsN, '0);
        end

        // Commit, then boundary three edges later
        bus.i_commit = 1'b1; push_commit(); step(); bus.i_commit = 1'b0;
        chk("c1_pending", BW'(bus.o_commitPending), BW'(1));
        chk("c1_ready_low", BW'(bus.o_wrReady), '0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("c1_hold_N", bus.o_coefficientsN, '0);
            chk("c1_hold_done", BW'(bus.o_commitDone), '0);
        end
        bus.i_frameDone = 1'b1; step(); bus.i_frameDone = 1'b0;
        chk("c1_done", BW'(bus.o_commitDone), BW'(1));
        chk("c1_N", bus.o_coefficientsN, sh_model[0]);
        chk("c1_Nm1", bus.o_coefficientsNMinus1, sh_model[1]);
        chk("c1_N_center", BW'(bus.o_coefficientsN[c_tapCenter]), BW'(32'h0000045f));
        step();
        chk("c1_done_1cyc", BW'(bus.o_commitDone), '0);
        chk("c1_pending_clr", BW'(bus.o_commitPending), '0);
`ifdef COEFF_SCHED_READBACK_EN
        bus.i_rdBank = 1'b1; bus.i_rdShadow = 1'b0; bus.i_rdAddr = 4'd6; step();
        chk("rd_active_Nm1_6", BW'(bus.o_rdData), BW'(32'hffff0015));
        bus.i_rdAddr = 4'd14; step();
        chk("rd_oob", BW'(bus.o_rdData), '0);
`endif

        // Commit coinciding with a boundary: that boundary is skipped
        do_write(1'b0, 4'd0, 32'h00001111);
        bus.i_commit = 1'b1; bus.i_frameDone = 1'b1; push_commit(); step();
        bus.i_commit = 1'b0; bus.i_frameDone = 1'b0;
        chk("s_pending", BW'(bus.o_commitPending), BW'(1));
        chk("s_no_done", BW'(bus.o_commitDone), '0);
        chk("s_hold_N", bus.o_coefficientsN, act_model[0]);
        step(); step();
        chk("s_still_pending", BW'(bus.o_commitPending), BW'(1));
        bus.i_commit = 1'b1; step(); bus.i_commit = 1'b0; // ignored while pending
        bus.i_frameDone = 1'b1; step(); bus.i_frameDone = 1'b0;
        chk("s_done", BW'(bus.o_commitDone), BW'(1));
        chk("s_N", bus.o_coefficientsN, sh_model[0]);
        step();
        chk("s_pending_clr", BW'(bus.o_commitPending), '0);

        // Out-of-range write: accepted, shadow untouched, sticky error
        do_write(1'b1, 4'd13, 32'h12345678);
        chk("oob_err", BW'(bus.o_addrError), BW'(1));
        bus.i_commit = 1'b1; push_commit(); step(); bus.i_commit = 1'b0;
        bus.i_frameDone = 1'b1; step(); bus.i_frameDone = 1'b0;
        chk("oob_Nm1", bus.o_coefficientsNMinus1, sh_model[1]);
        step(); step();
        chk("oob_err_sticky", BW'(bus.o_addrError), BW'(1));
        chk("frames_model", BW'(bus.o_frameCount), BW'(exp_frames));

        // Counter wrap
        force dut.frame_count_q = 32'hFFFFFFFE;
        #1 release dut.frame_count_q;
        bus.i_frameDone = 1'b1;
        step(); chk("wrap_ffffffff", BW'(bus.o_frameCount), BW'(32'hFFFFFFFF));
        step(); chk("wrap_0", BW'(bus.o_frameCount), '0);
        step(); chk("wrap_1", BW'(bus.o_frameCount), BW'(1));
        bus.i_frameDone = 1'b0;

        // Async reset while a commit is pending
        do_write(1'b0, 4'd6, 32'h0bad0001);
`ifdef COEFF_SCHED_READBACK_EN
        bus.i_rdBank = 1'b0; bus.i_rdShadow = 1'b1; bus.i_rdAddr = 4'd6; step();
        chk("rd_shadow_N6", BW'(bus.o_rdData), BW'(32'h0bad0001));
`endif
        bus.i_commit = 1'b1; push_commit(); step(); bus.i_commit = 1'b0;
        chk("r_pending", BW'(bus.o_commitPending), BW'(1));
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        for (int b = 0; b < 2; b++) begin sh_model[b] = '0; act_model[b] = '0; end
        exp_frames = 0;
        chk("r_coefN_zero", bus.o_coefficientsN, '0);
        chk("r_coefNm1_zero", bus.o_coefficientsNMinus1, '0);
        chk("r_pending_zero", BW'(bus.o_commitPending), '0);
        chk("r_err_zero", BW'(bus.o_addrError), '0);
        chk("r_frames_zero", BW'(bus.o_frameCount), '0);
        step();
        rst = 1'b0;
        bus.i_frameDone = 1'b1; step(); bus.i_frameDone = 1'b0;
        chk("r_no_done", BW'(bus.o_commitDone), '0);
        chk("r_coefN_after", bus.o_coefficientsN, '0);
        chk("r_frames_after", BW'(bus.o_frameCount), BW'(exp_frames));
`ifdef COEFF_SCHED_READBACK_EN
        bus.i_rdBank = 1'b0; bus.i_rdShadow = 1'b1; bus.i_rdAddr = 4'd6; step();
        chk("r_rd_shadow_N6", BW'(bus.o_rdData), '0);
`endif
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/coefficient_scheduler.md
Name: coefficient_scheduler

Overview:
- Owns the two 13-entry coefficient vectors (N and N-1) that drive processingGrid.
- Host writes go into a shadow bank through a valid/ready port. A commit request copies the shadow bank into the active bank only at a timestep boundary, so coefficients never change in the middle of a grid sweep.
- Also counts completed timesteps. Sits between host/config logic and the processingGrid coefficient inputs.

Parameters:
g_numCoeff, 13, stencil taps per bank; must equal the length of t_coefficients
g_dataWidth, c_datawidth (32), coefficient width in signed fixed point, c_fractionlength fractional bits
g_addrWidth, 4, write address width; must satisfy 2**g_addrWidth >= g_numCoeff

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_wrValid  in  1  write request
o_wrReady  out  1  write accepted when high together with i_wrValid
i_wrBank  in  1  0 = N bank, 1 = N-1 bank
i_wrAddr  in  g_addrWidth  tap index, matching the stencil order of t_coefficients
i_wrData  in  g_dataWidth  coefficient value
i_commit  in  1  single-cycle request to publish the shadow bank
o_commitPending  out  1  a commit is waiting for a boundary
o_commitDone  out  1  one-cycle pulse, high on the cycle the active bank changes
i_frameDone  in  1  timestep boundary; driven by the grid o_outputReady
o_coefficientsN  out  t_coefficients  active N bank, to the grid i_coefficientsN
o_coefficientsNMinus1  out  t_coefficients  active N-1 bank
o_frameCount  out  32  completed timesteps
o_addrError  out  1  sticky flag: a write with address >= g_numCoeff occurred

Behaviour:
- Reset (asynchronous, i_reset=1):
  - Shadow and active banks all zero.
  - o_frameCount=0; o_commitPending=0; o_commitDone=0; o_addrError=0; o_wrReady=0.
  - FSM goes to IDLE.
- FSM IDLE:
  - o_wrReady=1.
  - A write is accepted on a clock edge where i_wrValid=1; it updates the shadow entry [i_wrBank][i_wrAddr] at that edge.
  - i_commit=1 moves the FSM to PENDING at the same edge.
- FSM PENDING:
  - o_wrReady=0 and o_commitPending=1.
  - On the first edge where i_frameDone=1: active <= shadow (both banks, all taps, one edge), o_commitDone=1 for the next cycle, FSM returns to IDLE.
- Write and commit in the same cycle (IDLE): the write is applied first and is included in the committed data.
- Commit and i_frameDone in the same cycle (IDLE): that boundary is not used; the swap happens at the next i_frameDone. This guarantees a full grid sweep between request and swap.
- i_commit while PENDING: ignored; no queueing, no error.
- The shadow bank keeps its contents after a swap, so later writes are incremental edits.
- Address out of range: write is accepted (o_wrReady handshake completes), shadow is unchanged, o_addrError is set and stays set until reset.
- o_frameCount increments on every edge with i_frameDone=1, in any state, and wraps from 0xFFFFFFFF to 0.
- Outputs o_coefficientsN/o_coefficientsNMinus1 are registered and driven directly from the active bank; there is no combinational path from inputs.
- Reset mid-PENDING: the commit is discarded, all banks are zeroed, and no o_commitDone pulse is produced.

Optional Feature:
COEFF_SCHED_READBACK_EN
- Defined:
  - Adds ports i_rdBank(1), i_rdShadow(1), i_rdAddr(g_addrWidth), o_rdData(g_dataWidth).
  - Reads the selected bank (active or shadow) with a registered one-cycle latency.
  - An out-of-range address reads 0.
  - o_rdData resets to 0.
- Undefined: these ports and the read logic do not exist; all other behaviour is identical.

Decomposition:
- pkg_audiovhd:
  - Add c_numCoeff=13 and typedef t_coeffBank (array of c_numCoeff by c_datawidth), which is compatible with t_coefficients.
  - Add enum t_schedState {IDLE, PENDING}.
  - Add the tap-index constants c_tapCenter=6, c_tapNorth=2, c_tapSouth=10, c_tapEast=7, c_tapWest=5.
- Sub-module coeff_bank: one shadow and active register pair with the write port, copy strobe and optional read mux. Instantiate it twice (N and N-1); the FSM and frame counter stay in the top module.

Test Plan:
- Reset then idle for 5 cycles -> both coefficient outputs all 0, o_frameCount=0, o_wrReady=1.
- Write N[6]=0x0000045f, N[2,5,7,10]=0x00007ee3, N-1[6]=0xffff0015, then commit, then i_frameDone pulse 3 cycles later:
  - outputs unchanged until that edge;
  - o_commitDone high exactly one cycle;
  - outputs then equal the written values.
- i_commit and i_frameDone in the same cycle -> no swap; the swap occurs at the following i_frameDone; o_commitPending=1 between the two.
- Write with address 13 (data 0x12345678) -> o_addrError=1 (sticky), no shadow change, handshake completes.
- Preload o_frameCount near 0xFFFFFFFE (force or 2^32 pulses in a fast model), then 3 i_frameDone pulses -> counter reads 0xFFFFFFFF, 0x0, 0x1.
- Assert i_reset asynchronously mid-PENDING -> outputs zero immediately, no o_commitDone pulse; with COEFF_SCHED_READBACK_EN, a shadow read of N[6] returns 0 one cycle after the read request.
